ctrl_decode_stage: RTL and testbench

//  Registered successor to the combinational control unit: decodes the fetched MIPS word into a

---
 rtl/ctrl_decode_stage.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_stage.sv
// ID/EX control register: decodes the fetched MIPS word into a control bundle and latches it.
// Adds stall/flush handling, a data-memory wait state and a halt-drain sequence.

package cpu_types_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        logic        valid;
        aluop_t      aluop;
        logic [1:0]  alusrc;
        logic [1:0]  regdest;
        logic [1:0]  pcsrc;
        logic        wen;
        logic        memtoreg;
        logic        dren;
        logic        dwen;
        logic        extop;
        logic        lui;
        logic        beq;
        logic        branch;
        logic        jal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] immed;
    } ctrl_t;

endpackage

module ctrl_decode_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int HALT_DRAIN = 3,
    parameter bit MEM_FSM    = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              instr_valid,
    input  logic [WORD_W-1:0] instruction,
    input  logic              stall,
    input  logic              flush,
    input  logic              dhit,
    output logic              ctl_valid,
    output aluop_t            ALUop,
    output logic [1:0]        ALUsrc,
    output logic [1:0]        RegDest,
    output logic [1:0]        pcsrc,
    output logic              WEN,
    output logic              MemtoReg,
    output logic              dREN,
    output logic              dWEN,
    output logic              extop,
    output logic              LUI,
    output logic              BEQ,
    output logic              branch,
    output logic              jal,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       immed,
    output logic              imemREN,
    output logic              mem_busy,
    output logic              halt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    // Counter holds the DRAIN edges still to pass before the edge that enters HALTED.
    localparam logic [3:0] DRAIN_LOAD = 4'(HALT_DRAIN);

    state_t     state_reg, state_next;
    ctrl_t      ctl_reg, ctl_next;
    ctrl_t      dec;
    logic [3:0] cnt_reg, cnt_next;
    logic       halt_reg, halt_next;
    logic [5:0] op;
    logic [5:0] fn;
    logic       is_halt;

    assign op      = instruction[31:26];
    assign fn      = instruction[5:0];
    assign is_halt = (op == OP_HALT);

    always_comb begin
        dec = '0;
        dec.aluop = ALU_ADD;
        dec.valid = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec.regdest = 2'b01;
                dec.wen     = 1'b1;
                case (fn)
                    FN_SLL:  begin dec.aluop = ALU_SLL; dec.alusrc = 2'b10; end
                    FN_SRL:  begin dec.aluop = ALU_SRL; dec.alusrc = 2'b10; end
                    FN_SLLV: dec.aluop = ALU_SLL;
                    FN_SRLV: dec.aluop = ALU_SRL;
                    FN_JR:   begin dec.wen = 1'b0; dec.pcsrc = 2'b11; end
                    FN_ADD, FN_ADDU: dec.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.aluop = ALU_SUB;
                    FN_AND:  dec.aluop = ALU_AND;
                    FN_OR:   dec.aluop = ALU_OR;
                    FN_XOR:  dec.aluop = ALU_XOR;
                    FN_NOR:  dec.aluop = ALU_NOR;
                    FN_SLT:  dec.aluop = ALU_SLT;
                    FN_SLTU: dec.aluop = ALU_SLTU;
                    default: dec.valid = 1'b0;
                endcase
            end
            OP_J:   dec.pcsrc = 2'b10;
            OP_JAL: begin
                dec.pcsrc   = 2'b10;
                dec.wen     = 1'b1;
                dec.regdest = 2'b10;
                dec.jal     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.aluop  = ALU_SUB;
                dec.pcsrc  = 2'b01;
                dec.extop  = 1'b1;
                dec.branch = 1'b1;
                dec.beq    = (op == OP_BEQ);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.alusrc = 2'b01;
                dec.extop  = 1'b1;
                dec.wen    = 1'b1;
                if (op == OP_SLTI)
                    dec.aluop = ALU_SLT;
                else if (op == OP_SLTIU)
                    dec.aluop = ALU_SLTU;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.alusrc = 2'b01;
                dec.wen    = 1'b1;
                if (op == OP_ANDI)
                    dec.aluop = ALU_AND;
                else if (op == OP_ORI)
                    dec.aluop = ALU_OR;
                else
                    dec.aluop = ALU_XOR;
            end
            OP_LUI: begin
                dec.alusrc = 2'b01;
                dec.wen    = 1'b1;
                dec.lui    = 1'b1;
            end
            OP_LW: begin
                dec.alusrc   = 2'b01;
                dec.extop    = 1'b1;
                dec.wen      = 1'b1;
                dec.memtoreg = 1'b1;
                dec.dren     = 1'b1;
            end
            OP_SW: begin
                dec.alusrc = 2'b01;
                dec.extop  = 1'b1;
                dec.dwen   = 1'b1;
            end
            default: dec.valid = 1'b0;
        endcase
        // Unknown opcodes and functs (HALT included) collapse to an all-zero bubble.
        if (dec.valid) begin
            dec.rs    = instruction[25:21];
            dec.rt    = instruction[20:16];
            dec.rd    = instruction[15:11];
            dec.shamt = instruction[10:6];
            dec.immed = instruction[15:0];
        end else begin
            dec = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        ctl_next   = ctl_reg;
        cnt_next   = cnt_reg;
        halt_next  = halt_reg;
        case (state_reg)
            ST_RUN: begin
                if (flush) begin
                    ctl_next = '0;
                end else if (stall) begin
                    ctl_next = ctl_reg;
                end else if (!instr_valid) begin
                    ctl_next = '0;
                end else if (is_halt) begin
                    ctl_next   = '0;
                    cnt_next   = DRAIN_LOAD;
                    state_next = ST_DRAIN;
                end else begin
                    ctl_next = dec;
                    if (MEM_FSM && (dec.dren || dec.dwen))
                        state_next = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (dhit) begin
                    ctl_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                ctl_next = '0;
                if (cnt_reg == 4'd0) begin
                    state_next = ST_HALTED;
                    halt_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                ctl_next  = '0;
                halt_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_RUN;
            ctl_reg   <= '0;
            cnt_reg   <= 4'd0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctl_reg   <= ctl_next;
            cnt_reg   <= cnt_next;
            halt_reg  <= halt_next;
        end
    end

    assign ctl_valid = ctl_reg.valid;
    assign ALUop     = ctl_reg.aluop;
    assign ALUsrc    = ctl_reg.alusrc;
    assign RegDest   = ctl_reg.regdest;
    assign pcsrc     = ctl_reg.pcsrc;
    assign WEN       = ctl_reg.wen;
    assign MemtoReg  = ctl_reg.memtoreg;
    assign dREN      = ctl_reg.dren;
    assign dWEN      = ctl_reg.dwen;
    assign extop     = ctl_reg.extop;
    assign LUI       = ctl_reg.lui;
    assign BEQ       = ctl_reg.beq;
    assign branch    = ctl_reg.branch;
    assign jal       = ctl_reg.jal;
    assign rs        = ctl_reg.rs;
    assign rt        = ctl_reg.rt;
    assign rd        = ctl_reg.rd;
    assign shamt     = ctl_reg.shamt;
    assign immed     = ctl_reg.immed;
    assign halt      = halt_reg;

    // The single memory port is lent to the data side outside RUN.
    assign imemREN   = (state_reg == ST_RUN);
    assign mem_busy  = MEM_FSM && (state_reg == ST_MEMWAIT);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: two instances (MEM_FSM=0/HALT_DRAIN=1 and MEM_FSM=1/HALT_DRAIN=3)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_ctrl_decode_stage;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic [1:0]  alusrc;
        logic [1:0]  regdest;
        logic [1:0]  pcsrc;
        logic        wen;
        logic        memtoreg;
        logic        dren;
        logic        dwen;
        logic        extop;
        logic        lui;
        logic        beq;
        logic        branch;
        logic        jal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] immed;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        stall, flush, dhit;

    logic ctl_valid0, WEN0, MemtoReg0, dREN0, dWEN0, extop0, LUI0, BEQ0, branch0, jal0;
    logic ctl_valid1, WEN1, MemtoReg1, dREN1, dWEN1, extop1, LUI1, BEQ1, branch1, jal1;
    aluop_t ALUop0, ALUop1;
    logic [1:0] ALUsrc0, RegDest0, pcsrc0, ALUsrc1, RegDest1, pcsrc1;
    logic [4:0] rs0, rt0, rd0, shamt0, rs1, rt1, rd1, shamt1;
    logic [15:0] immed0, immed1;
    logic imemREN0, mem_busy0, halt0, imemREN1, mem_busy1, halt1;

    always #5 clk = ~clk;

    ctrl_decode_stage #(.WORD_W(32), .HALT_DRAIN(1), .MEM_FSM(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .instr_valid(instr_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .dhit(dhit),
        .ctl_valid(ctl_valid0), .ALUop(ALUop0), .ALUsrc(ALUsrc0), .RegDest(RegDest0),
        .pcsrc(pcsrc0), .WEN(WEN0), .MemtoReg(MemtoReg0), .dREN(dREN0), .dWEN(dWEN0),
        .extop(extop0), .LUI(LUI0), .BEQ(BEQ0), .branch(branch0), .jal(jal0),
        .rs(rs0), .rt(rt0), .rd(rd0), .shamt(shamt0), .immed(immed0),
        .imemREN(imemREN0), .mem_busy(mem_busy0), .halt(halt0)
    );

    ctrl_decode_stage #(.WORD_W(32), .HALT_DRAIN(3), .MEM_FSM(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .instr_valid(instr_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .dhit(dhit),
        .ctl_valid(ctl_valid1), .ALUop(ALUop1), .ALUsrc(ALUsrc1), .RegDest(RegDest1),
        .pcsrc(pcsrc1), .WEN(WEN1), .MemtoReg(MemtoReg1), .dREN(dREN1), .dWEN(dWEN1),
        .extop(extop1), .LUI(LUI1), .BEQ(BEQ1), .branch(branch1), .jal(jal1),
        .rs(rs1), .rt(rt1), .rd(rd1), .shamt(shamt1), .immed(immed1),
        .imemREN(imemREN1), .mem_busy(mem_busy1), .halt(halt1)
    );

    bundle_t obs [2];
    assign obs[0] = {ctl_valid0, 4'(ALUop0), ALUsrc0, RegDest0, pcsrc0, WEN0, MemtoReg0, dREN0,
                     dWEN0, extop0, LUI0, BEQ0, branch0, jal0, rs0, rt0, rd0, shamt0, immed0};
    assign obs[1] = {ctl_valid1, 4'(ALUop1), ALUsrc1, RegDest1, pcsrc1, WEN1, MemtoReg1, dREN1,
                     dWEN1, extop1, LUI1, BEQ1, branch1, jal1, rs1, rt1, rd1, shamt1, immed1};

    // Reference model state, per instance
    int      n_cmp = 0;
    int      n_err = 0;
    bit      mf [2] = '{1'b0, 1'b1};
    int      hd [2] = '{1, 3};
    bundle_t m_exp [2];
    bit      m_mem [2];
    int      m_left [2];
    bit      m_halt [2];

    function automatic bundle_t ref_decode(input logic [31:0] w);
        bundle_t b = '0;
        int  op = int'(w[31:26]);
        int  fn = int'(w[5:0]);
        bit  is_r = (op == 0);
        bit  is_jr = is_r && (fn == 8);
        bit  known = (is_r && (fn inside {0, 2, 4, 6, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43}))
                     || (op inside {2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43});
        if (!known) return b;
        b.valid    = 1'b1;
        b.wen      = !(op inside {2, 4, 5, 43}) && !is_jr;
        b.regdest  = is_r ? 2'd1 : ((op == 3) ? 2'd2 : 2'd0);
        b.alusrc   = (is_r && (fn inside {0, 2})) ? 2'd2 : ((is_r || (op inside {2, 3, 4, 5})) ? 2'd0 : 2'd1);
        b.pcsrc    = (op inside {4, 5}) ? 2'd1 : ((op inside {2, 3}) ? 2'd2 : (is_jr ? 2'd3 : 2'd0));
        b.extop    = op inside {4, 5, 8, 9, 10, 11, 35, 43};
        b.memtoreg = (op == 35);
        b.dren     = (op == 35);
        b.dwen     = (op == 43);
        b.lui      = (op == 15);
        b.beq      = (op == 4);
        b.branch   = (op inside {4, 5});
        b.jal      = (op == 3);
        if (is_r) begin
            case (fn)
                0, 4:          b.aluop = ALU_SLL;
                2, 6:          b.aluop = ALU_SRL;
                34, 35:        b.aluop = ALU_SUB;
                36:            b.aluop = ALU_AND;
                37:            b.aluop = ALU_OR;
                38:            b.aluop = ALU_XOR;
                39:            b.aluop = ALU_NOR;
                42:            b.aluop = ALU_SLT;
                43:            b.aluop = ALU_SLTU;
                default:       b.aluop = ALU_ADD;
            endcase
        end else begin
            case (op)
                4, 5:    b.aluop = ALU_SUB;
                10:      b.aluop = ALU_SLT;
                11:      b.aluop = ALU_SLTU;
                12:      b.aluop = ALU_AND;
                13:      b.aluop = ALU_OR;
                14:      b.aluop = ALU_XOR;
                default: b.aluop = ALU_ADD;
            endcase
        end
        b.rs = w[25:21]; b.rt = w[20:16]; b.rd = w[15:11]; b.shamt = w[10:6]; b.immed = w[15:0];
        return b;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [5:0] op_pool [18] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                     6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h11};
        logic [5:0] fn_pool [16] = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd32, 6'd33, 6'd34, 6'd35,
                                     6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'h3a};
        logic [31:0] w = $urandom;
        w[31:26] = op_pool[$urandom_range(0, 17)];
        if (w[31:26] == 6'h00) w[5:0] = fn_pool[$urandom_range(0, 15)];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_exp[i] = '0; m_mem[i] = 1'b0; m_left[i] = 0; m_halt[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (m_halt[i]) begin
                m_exp[i] = '0;
            end else if (m_left[i] > 0) begin
                m_exp[i] = '0;
                m_left[i]--;
                if (m_left[i] == 0) m_halt[i] = 1'b1;
            end else if (m_mem[i]) begin
                if (dhit) begin m_exp[i] = '0; m_mem[i] = 1'b0; end
            end else if (flush || (!stall && !instr_valid)) begin
                m_exp[i] = '0;
            end else if (!stall) begin
                if (instruction[31:26] == 6'h3f) begin
                    m_exp[i]  = '0;
                    m_left[i] = hd[i] + 1;
                end else begin
                    m_exp[i] = ref_decode(instruction);
                    if (mf[i] && (m_exp[i].dren || m_exp[i].dwen)) m_mem[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_bundle%0d", tag, i), 64'(obs[i]), 64'(m_exp[i]));
            check($sformatf("%s_imemREN%0d", tag, i), 64'(i == 0 ? imemREN0 : imemREN1),
                  64'(!(m_mem[i] || m_left[i] > 0 || m_halt[i])));
            check($sformatf("%s_mem_busy%0d", tag, i), 64'(i == 0 ? mem_busy0 : mem_busy1), 64'(m_mem[i]));
            check($sformatf("%s_halt%0d", tag, i), 64'(i == 0 ? halt0 : halt1), 64'(m_halt[i]));
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] w, input logic s, input logic f,
                         input logic d, input string tag);
        instr_valid = v; instruction = w; stall = s; flush = f; dhit = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
        $display("cyc %s v=%0b w=%08h s=%0b f=%0b d=%0b | valid0=%0b valid1=%0b busy1=%0b halt0=%0b halt1=%0b",
                 tag, v, w, s, f, d, ctl_valid0, ctl_valid1, mem_busy1, halt0, halt1);
    endtask

    localparam logic [31:0] W_ADDU = 32'h00221821;
    localparam logic [31:0] W_LW   = 32'h8C220004;
    localparam logic [31:0] W_SW   = 32'hAC220008;
    localparam logic [31:0] W_BEQ  = 32'h10220003;
    localparam logic [31:0] W_HALT = 32'hFFFFFFFF;

    initial begin
        int dren_cycles;
        rst = 1'b1; instr_valid = 1'b0; instruction = '0; stall = 1'b0; flush = 1'b0; dhit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // addu $3,$1,$2
        cycle(1'b1, W_ADDU, 1'b0, 1'b0, 1'b0, "addu");
        check("addu_fields", {62'd0, WEN1, ctl_valid1}, 64'd3);
        check("addu_regs", {49'd0, RegDest1, rs1, rt1, rd1}, {49'd0, 2'd1, 5'd1, 5'd2, 5'd3});

        // lw with dhit high in the latch cycle (ignored), then low for 3 cycles, then high
        dren_cycles = 0;
        cycle(1'b1, W_LW, 1'b0, 1'b0, 1'b1, "lw_latch");
        if (dREN1 && mem_busy1 && !imemREN1) dren_cycles++;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, W_ADDU, 1'b1, 1'b1, (k == 3), "lw_wait");
            if (dREN1 && mem_busy1 && !imemREN1) dren_cycles++;
        end
        check("lw_busy_cycles", 64'(dren_cycles), 64'd4);

        // stall and flush together with beq: flush wins
        cycle(1'b1, W_ADDU, 1'b0, 1'b0, 1'b0, "pre_beq");
        cycle(1'b1, W_BEQ, 1'b1, 1'b1, 1'b0, "beq_flush");
        check("beq_flush_bubble", {62'd0, ctl_valid1, branch1}, 64'd0);
        cycle(1'b1, W_BEQ, 1'b0, 1'b0, 1'b0, "beq");
        cycle(1'b1, W_ADDU, 1'b1, 1'b0, 1'b0, "beq_stall");
        check("beq_stall_hold", {62'd0, BEQ1, branch1}, 64'd3);

        // sw then addu on consecutive cycles
        cycle(1'b1, W_SW, 1'b0, 1'b0, 1'b0, "sw");
        check("sw_nofsm", {61'd0, dWEN0, mem_busy0, mem_busy1}, 64'b101);
        cycle(1'b1, W_ADDU, 1'b0, 1'b0, 1'b0, "sw_addu");
        check("sw_addu_nofsm", {62'd0, dWEN0, WEN0}, 64'b01);
        cycle(1'b0, W_ADDU, 1'b0, 1'b0, 1'b0, "sw_hold");

        // asynchronous reset in the middle of MEMWAIT
        check("pre_rst_busy", 64'(mem_busy1), 64'd1);
        #1 rst = 1'b1;
        #1 model_reset();
        check_all("rst_async");
        check("rst_async_imem", {62'd0, imemREN1, dWEN1}, 64'b10);
        #1 rst = 1'b0;

        // HALT dropped under flush, ignored when not valid, held off by stall
        cycle(1'b1, W_HALT, 1'b0, 1'b1, 1'b0, "halt_flush");
        cycle(1'b0, W_HALT, 1'b0, 1'b0, 1'b0, "halt_invalid");
        cycle(1'b1, W_HALT, 1'b1, 1'b0, 1'b0, "halt_stall");

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 7) != 0), rand_word(), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), "rand");
        end

        // settle out of any MEMWAIT, then HALT and keep feeding traffic
        cycle(1'b0, W_ADDU, 1'b0, 1'b0, 1'b1, "settle");
        cycle(1'b1, W_HALT, 1'b0, 1'b0, 1'b0, "halt");
        check("halt_imem_off", {62'd0, imemREN0, imemREN1}, 64'd0);
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, (k % 2 == 0) ? W_ADDU : W_LW, ($urandom_range(0, 1) == 1), (k % 3 == 0),
                  1'b1, "halted");
            check($sformatf("halt1_edge%0d", k), 64'(halt1), 64'(k >= 4));
            check($sformatf("halt0_edge%0d", k), 64'(halt0), 64'(k >= 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
